// File: rtl/fft_power_avg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : fft_power_avg                                                |
// | Description : Per-bin FFT power (re^2 + im^2) averaged over 2^L frames in  |
// |               an internal accumulator RAM; one averaged spectrum out per   |
// |               2^L input frames, fixed 4-cycle strobe_in->strobe_out path.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_power_avg #(
  parameter int IN_W         = 16,
  parameter int FFT_LEN      = 1024,
  parameter int MAX_LOG2_AVG = 8,
  parameter int OUT_W        = 32,
  parameter int SR_BASE      = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic                       strobe_in,
  input  logic                       sof_in,
  input  logic signed [IN_W-1:0]     xk_re,
  input  logic signed [IN_W-1:0]     xk_im,
  output logic                       strobe_out,
  output logic                       sof_out,
  output logic [$clog2(FFT_LEN)-1:0] bin_idx,
  output logic [OUT_W-1:0]           xk_pwr,
  output logic                       frame_err
);

  localparam int BIN_W = $clog2(FFT_LEN);
  localparam int P_W   = 2 * IN_W;
  localparam int ACC_W = P_W + MAX_LOG2_AVG;
  localparam int FC_W  = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [3:0]       C_MAX_L    = 4'(MAX_LOG2_AVG);
  localparam logic [7:0]       C_SR_CTRL  = 8'(SR_BASE);
  localparam logic [7:0]       C_SR_AVG   = 8'(SR_BASE + 1);
  localparam logic [BIN_W-1:0] C_LAST_BIN = BIN_W'(FFT_LEN - 1);
  localparam logic [CMP_W-1:0] C_OUT_MAX  = CMP_W'({OUT_W{1'b1}});

  typedef enum logic [0:0] {ST_WAIT_SOF = 1'b0, ST_ACCUM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               enable_q, enable_d;
  logic [3:0]         log2_avg_q, log2_avg_d;
  logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic               frame_err_q, frame_err_d;

  // Bin accepted into the pipeline this cycle, with its index and frame number
  logic               w_acc_vld;
  logic [BIN_W-1:0]   w_acc_bin;
  logic [FC_W-1:0]    w_acc_fc;

  logic               w_wr_ctrl, w_wr_avg;
  logic [3:0]         w_l_new;
  logic [FC_W:0]      w_fc_lim;
  logic [FC_W-1:0]    w_fc_max;
  logic               w_unused;

  // Pipeline registers
  logic               v1_q, zero1_q, last1_q;
  logic [BIN_W-1:0]   bin1_q;
  logic signed [IN_W-1:0] re1_q, im1_q;
  logic               v2_q, zero2_q, last2_q;
  logic [BIN_W-1:0]   bin2_q;
  logic [P_W-1:0]     p2_q;
  logic               v3_q, last3_q;
  logic [BIN_W-1:0]   bin3_q;
  logic [ACC_W-1:0]   sum3_q;
  logic [ACC_W-1:0]   rd_q;
  logic [ACC_W-1:0]   mem_q [FFT_LEN];

  logic               strobe_out_q, sof_out_q;
  logic [BIN_W-1:0]   bin_idx_q;
  logic [OUT_W-1:0]   xk_pwr_q;

  logic signed [P_W-1:0] w_re_sq, w_im_sq;
  logic [P_W-1:0]     w_p;
  logic [ACC_W-1:0]   w_shifted;
  logic [CMP_W-1:0]   w_shift_ext;
  logic [OUT_W-1:0]   w_pwr_sat;

  assign w_wr_ctrl = set_stb && (set_addr == C_SR_CTRL);
  assign w_wr_avg  = set_stb && (set_addr == C_SR_AVG);
  assign w_l_new   = (set_data[3:0] > C_MAX_L) ? C_MAX_L : set_data[3:0];

  // Last frame number of an averaging run is 2^L - 1
  assign w_fc_lim  = ((FC_W+1)'(1) << log2_avg_q) - (FC_W+1)'(1);
  assign w_fc_max  = w_fc_lim[FC_W-1:0];
  assign w_unused  = &{1'b0, set_data[31:4], w_fc_lim[FC_W]};

  // Control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WAIT_SOF;
      enable_q    <= 1'b0;
      log2_avg_q  <= 4'd0;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      log2_avg_q  <= log2_avg_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Settings decode and frame tracking; settings writes win over a same-cycle bin
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    log2_avg_d  = log2_avg_q;
    bin_cnt_d   = bin_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = frame_err_q;
    w_acc_vld   = 1'b0;
    w_acc_bin   = bin_cnt_q;
    w_acc_fc    = frame_cnt_q;
    if (w_wr_ctrl) begin
      enable_d = set_data[0];
      if (set_data[1] || !set_data[0]) begin
        state_d     = ST_WAIT_SOF;
        frame_cnt_d = '0;
        bin_cnt_d   = '0;
      end
      if (set_data[1]) begin
        frame_err_d = 1'b0;
      end
    end else if (w_wr_avg) begin
      log2_avg_d  = w_l_new;
      state_d     = ST_WAIT_SOF;
      frame_cnt_d = '0;
      bin_cnt_d   = '0;
    end else if (!enable_q) begin
      state_d = ST_WAIT_SOF;
    end else if (strobe_in) begin
      case (state_q)
        ST_WAIT_SOF: begin
          if (sof_in) begin
            w_acc_vld   = 1'b1;
            w_acc_bin   = '0;
            w_acc_fc    = '0;
            bin_cnt_d   = BIN_W'(1);
            frame_cnt_d = '0;
            state_d     = ST_ACCUM;
          end
        end
        default: begin
          if (sof_in && (bin_cnt_q != '0)) begin
            // Short frame: abandon partial averages, sof bin opens a new run
            frame_err_d = 1'b1;
            w_acc_vld   = 1'b1;
            w_acc_bin   = '0;
            w_acc_fc    = '0;
            bin_cnt_d   = BIN_W'(1);
            frame_cnt_d = '0;
          end else if (!sof_in && (bin_cnt_q == '0)) begin
            // Long frame: drop the bin and resynchronise on the next sof
            frame_err_d = 1'b1;
            frame_cnt_d = '0;
            state_d     = ST_WAIT_SOF;
          end else begin
            w_acc_vld = 1'b1;
            bin_cnt_d = bin_cnt_q + BIN_W'(1);
            if (bin_cnt_q == C_LAST_BIN) begin
              frame_cnt_d = (frame_cnt_q == w_fc_max) ? '0 : frame_cnt_q + FC_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Exact squared magnitude; both squares are non-negative so the sum fits unsigned
  assign w_re_sq = P_W'(re1_q) * P_W'(re1_q);
  assign w_im_sq = P_W'(im1_q) * P_W'(im1_q);
  assign w_p     = $unsigned(w_re_sq) + $unsigned(w_im_sq);

  assign w_shifted   = sum3_q >> log2_avg_q;
  assign w_shift_ext = CMP_W'(w_shifted);
  assign w_pwr_sat   = (w_shift_ext > C_OUT_MAX) ? {OUT_W{1'b1}} : w_shift_ext[OUT_W-1:0];

  // Four-stage datapath: capture, square, accumulate, write-back/emit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q         <= 1'b0;
      zero1_q      <= 1'b0;
      last1_q      <= 1'b0;
      bin1_q       <= '0;
      re1_q        <= '0;
      im1_q        <= '0;
      v2_q         <= 1'b0;
      zero2_q      <= 1'b0;
      last2_q      <= 1'b0;
      bin2_q       <= '0;
      p2_q         <= '0;
      v3_q         <= 1'b0;
      last3_q      <= 1'b0;
      bin3_q       <= '0;
      sum3_q       <= '0;
      strobe_out_q <= 1'b0;
      sof_out_q    <= 1'b0;
      bin_idx_q    <= '0;
      xk_pwr_q     <= '0;
    end else begin
      v1_q         <= w_acc_vld;
      zero1_q      <= (w_acc_fc == '0);
      last1_q      <= (w_acc_fc == w_fc_max);
      bin1_q       <= w_acc_bin;
      re1_q        <= xk_re;
      im1_q        <= xk_im;
      v2_q         <= v1_q;
      zero2_q      <= zero1_q;
      last2_q      <= last1_q;
      bin2_q       <= bin1_q;
      p2_q         <= w_p;
      v3_q         <= v2_q;
      last3_q      <= last2_q;
      bin3_q       <= bin2_q;
      sum3_q       <= ACC_W'(p2_q) + (zero2_q ? '0 : rd_q);
      strobe_out_q <= v3_q && last3_q;
      sof_out_q    <= v3_q && last3_q && (bin3_q == '0);
      if (v3_q && last3_q) begin
        bin_idx_q <= bin3_q;
        xk_pwr_q  <= w_pwr_sat;
      end
    end
  end

  // Accumulator RAM: one read port (stage 1 address), one write port (stage 3 result)
  always_ff @(posedge clock) begin
    rd_q <= mem_q[bin1_q];
    if (v3_q) begin
      mem_q[bin3_q] <= last3_q ? '0 : sum3_q;
    end
  end

  assign strobe_out = strobe_out_q;
  assign sof_out    = sof_out_q;
  assign bin_idx    = bin_idx_q;
  assign xk_pwr     = xk_pwr_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire
